sram_bus_arbiter: RTL

Two-master to one-slave arbiter that shares the single SRAM-like memory bus between the fetch-stage instruction port and the mem-stage data port of the pipelined CPU core. It serialises requests, holding one outstanding bus transaction at a time, with the data port at fixed higher priority. It generates per-port stall signals for the hazard unit and discards returned instruction words whose fetch was flushed by an exception.

---
 rtl/sram_bus_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
// Shares one SRAM-like memory bus between the fetch-stage instruction port and
// the mem-stage data port. One bus transaction is outstanding at a time, and the
// data port has fixed priority whenever the arbiter is idle. Fetches that are
// flushed while in flight still finish on the bus, but their data is discarded.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   inst_req/addr/cancel     fetch request, pc, flush pulse
//   inst_rdata/data_ok/stall fetch return word, one-cycle valid, stall to hazard unit
//   data_req/wr/size/addr/wdata  load/store request (size 0=byte 1=half 2=word)
//   data_rdata/data_ok/stall load return, one-cycle completion, stall to hazard unit
//   bus_req/wr/size/addr/wdata   registered request to the slave
//   bus_addr_ok/data_ok/rdata    slave address accept, data completion, read data
module sram_bus_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_cancel,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_data_ok,
    output logic              inst_stall,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_data_ok,
    output logic              data_stall,

    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DADDR = 3'd1,
        DWAIT = 3'd2,
        IADDR = 3'd3,
        IWAIT = 3'd4
    } state_t;

    state_t state;
    logic   drop;

    // Grant, address phase and data phase sequencing with registered bus fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            drop      <= 1'b0;
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_size  <= 2'd0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    drop <= 1'b0;
                    if (data_req) begin
                        state     <= DADDR;
                        bus_req   <= 1'b1;
                        bus_wr    <= data_wr;
                        bus_size  <= data_size;
                        bus_addr  <= data_addr;
                        bus_wdata <= data_wdata;
                    end else if (inst_req && !inst_cancel) begin
                        // a fetch being flushed this very cycle is not worth issuing
                        state    <= IADDR;
                        bus_req  <= 1'b1;
                        bus_wr   <= 1'b0;
                        bus_size <= SIZE_WORD;
                        bus_addr <= inst_addr;
                    end
                end
                DADDR: begin
                    if (bus_addr_ok) begin
                        state   <= DWAIT;
                        bus_req <= 1'b0;
                    end
                end
                DWAIT: begin
                    if (bus_data_ok) begin
                        state <= IDLE;
                    end
                end
                IADDR: begin
                    if (inst_cancel) begin
                        drop <= 1'b1;
                    end
                    if (bus_addr_ok) begin
                        state   <= IWAIT;
                        bus_req <= 1'b0;
                    end
                end
                IWAIT: begin
                    if (bus_data_ok) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                    end else if (inst_cancel) begin
                        drop <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    drop    <= 1'b0;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

    // Completion is passed straight through so requesters can drop req next cycle
    assign data_data_ok = (state == DWAIT) && bus_data_ok;
    // A cancel arriving together with the data still suppresses the word
    assign inst_data_ok = (state == IWAIT) && bus_data_ok && !(drop || inst_cancel);

    assign data_rdata = bus_rdata;
    assign inst_rdata = bus_rdata;

    // Stalls are gated by reset so the hazard unit sees a quiet pipeline
    assign data_stall = rst && data_req && !data_data_ok;
    assign inst_stall = rst && inst_req && !inst_data_ok;

endmodule
